fpu_div_seq: RTL and testbench

- Issue/sequencing stage directly upstream of the fp16 divide coprocessor (fpuDiv).
- Accepts tagged divide requests over valid/ready into a small operand FIFO and holds the operands stable for the divider.
- Pulses the divider's start, waits for its sticky done, then captures result, flags and condition codes into a response register.
- Re-arms the divider with a one-cycle local reset, because the divider's FSM only leaves DONE through reset.

---
 rtl/fpu_div_seq.sv | 198 +++++++++++++++++++
 tb/tb_fpu_div_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_seq.sv
// Sequencer in front of the fp16 divider: request FIFO, start/done handshake, response slot, divider re-arm.
// Optional macro FPU_DIV_SPECIAL_BYPASS_EN answers inf/NaN/zero operand cases locally, leaving the divider idle.
module fpu_div_seq #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [15:0]       reqA,
    input  logic [15:0]       reqB,
    input  logic [TAG_W-1:0]  reqTag,
    output logic              respValid,
    input  logic              respReady,
    output logic [15:0]       respResult,
    output logic [TAG_W-1:0]  respTag,
    output logic [FLAG_W-1:0] respFlags,
    output logic [3:0]        respCC,
    output logic              divStart,
    output logic              divReset,
    output logic [15:0]       divIn1,
    output logic [15:0]       divIn2,
    input  logic [15:0]       divOut,
    input  logic              divDone,
    input  logic [3:0]        divCC,
    input  logic [FLAG_W-1:0] divFlags
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] CLEAR  = 2'd3;

    logic [15:0]       mem_a   [DEPTH];
    logic [15:0]       mem_b   [DEPTH];
    logic [TAG_W-1:0]  mem_tag [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;

    logic [1:0]        state_reg;
    logic [15:0]       op_a_reg;
    logic [15:0]       op_b_reg;
    logic [TAG_W-1:0]  op_tag_reg;

    logic              resp_valid_reg;
    logic [15:0]       resp_result_reg;
    logic [TAG_W-1:0]  resp_tag_reg;
    logic [FLAG_W-1:0] resp_flags_reg;
    logic [3:0]        resp_cc_reg;

    logic              push;
    logic              pop;
    logic [15:0]       head_a;
    logic [15:0]       head_b;
    logic [TAG_W-1:0]  head_tag;

    // Full is judged on the registered count, so a pop frees a slot only from the next cycle.
    assign reqReady = !reset && (count_reg != FULL_CNT);
    assign push     = reqValid && reqReady;
    assign pop      = (state_reg == IDLE) && (count_reg != '0) && !resp_valid_reg;
    assign head_a   = mem_a[rd_ptr_reg];
    assign head_b   = mem_b[rd_ptr_reg];
    assign head_tag = mem_tag[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr_reg]   <= reqA;
            mem_b[wr_ptr_reg]   <= reqB;
            mem_tag[wr_ptr_reg] <= reqTag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push && !pop)
                count_reg <= count_reg + CNT_ONE;
            else if (!push && pop)
                count_reg <= count_reg - CNT_ONE;
        end
    end

`ifdef FPU_DIV_SPECIAL_BYPASS_EN
    localparam logic [FLAG_W-1:0] FLAG_NV = FLAG_W'(16);
    localparam logic [FLAG_W-1:0] FLAG_DZ = FLAG_W'(8);

    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, q_sign;
    logic              is_special;
    logic [15:0]       byp_result;
    logic [FLAG_W-1:0] byp_flags;

    always_comb begin
        a_nan      = (head_a[14:10] == 5'h1F) && (head_a[9:0] != '0);
        a_inf      = (head_a[14:10] == 5'h1F) && (head_a[9:0] == '0);
        a_zero     = (head_a[14:0] == '0);
        b_nan      = (head_b[14:10] == 5'h1F) && (head_b[9:0] != '0);
        b_inf      = (head_b[14:10] == 5'h1F) && (head_b[9:0] == '0);
        b_zero     = (head_b[14:0] == '0);
        q_sign     = head_a[15] ^ head_b[15];
        is_special = 1'b1;
        byp_result = '0;
        byp_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            byp_result = 16'h7E00;
            byp_flags  = FLAG_NV;
        end else if (a_inf) begin
            byp_result = {q_sign, 15'h7C00};
        end else if (b_zero) begin
            byp_result = {q_sign, 15'h7C00};
            byp_flags  = FLAG_DZ;
        end else if (b_inf || a_zero) begin
            byp_result = {q_sign, 15'h0000};
        end else begin
            is_special = 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            op_tag_reg      <= '0;
            resp_valid_reg  <= 1'b0;
            resp_result_reg <= '0;
            resp_tag_reg    <= '0;
            resp_flags_reg  <= '0;
            resp_cc_reg     <= '0;
        end else begin
            if (resp_valid_reg && respReady)
                resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
`ifdef FPU_DIV_SPECIAL_BYPASS_EN
                        if (is_special) begin
                            resp_valid_reg  <= 1'b1;
                            resp_result_reg <= byp_result;
                            resp_tag_reg    <= head_tag;
                            resp_flags_reg  <= byp_flags;
                            resp_cc_reg     <= {(byp_result[14:0] == '0), 1'b0, byp_result[15], 1'b0};
                        end else begin
                            op_a_reg   <= head_a;
                            op_b_reg   <= head_b;
                            op_tag_reg <= head_tag;
                            state_reg  <= LAUNCH;
                        end
`else
                        op_a_reg   <= head_a;
                        op_b_reg   <= head_b;
                        op_tag_reg <= head_tag;
                        state_reg  <= LAUNCH;
`endif
                    end
                end
                LAUNCH: state_reg <= WAIT;
                WAIT: begin
                    if (divDone) begin
                        resp_valid_reg  <= 1'b1;
                        resp_result_reg <= divOut;
                        resp_tag_reg    <= op_tag_reg;
                        resp_flags_reg  <= divFlags;
                        resp_cc_reg     <= divCC;
                        state_reg       <= CLEAR;
                    end
                end
                CLEAR: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The divider only leaves DONE through reset, so CLEAR doubles as its re-arm pulse.
    assign divStart   = (state_reg == LAUNCH);
    assign divReset   = reset || (state_reg == CLEAR);
    assign divIn1     = op_a_reg;
    assign divIn2     = op_b_reg;
    assign respValid  = resp_valid_reg;
    assign respResult = resp_result_reg;
    assign respTag    = resp_tag_reg;
    assign respFlags  = resp_flags_reg;
    assign respCC     = resp_cc_reg;
endmodule

// File: tb/tb_fpu_div_seq.sv
// Bench for fpu_div_seq: stand-in divider with random latency, scoreboard of expected responses.
// Define FPU_DIV_SPECIAL_BYPASS_EN for both files to exercise the local special-case path.
module tb_fpu_div_seq;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int FLAG_W = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic [15:0]       reqA = '0;
    logic [15:0]       reqB = '0;
    logic [TAG_W-1:0]  reqTag = '0;
    logic              respValid;
    logic              respReady = 1'b0;
    logic [15:0]       respResult;
    logic [TAG_W-1:0]  respTag;
    logic [FLAG_W-1:0] respFlags;
    logic [3:0]        respCC;
    logic              divStart;
    logic              divReset;
    logic [15:0]       divIn1;
    logic [15:0]       divIn2;
    logic [15:0]       divOut;
    logic              divDone;
    logic [3:0]        divCC;
    logic [FLAG_W-1:0] divFlags;

    fpu_div_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .FLAG_W(FLAG_W)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqA(reqA), .reqB(reqB), .reqTag(reqTag),
        .respValid(respValid), .respReady(respReady), .respResult(respResult),
        .respTag(respTag), .respFlags(respFlags), .respCC(respCC),
        .divStart(divStart), .divReset(divReset), .divIn1(divIn1), .divIn2(divIn2),
        .divOut(divOut), .divDone(divDone), .divCC(divCC), .divFlags(divFlags)
    );

    always #5 clock = ~clock;

    // Stand-in divider: arbitrary but deterministic quotient/flags/cc, sticky done until reset.
    function automatic logic [15:0] fake_q(input logic [15:0] a, input logic [15:0] b);
        return a - b + 16'h3C00;
    endfunction
    function automatic logic [FLAG_W-1:0] fake_f(input logic [15:0] a, input logic [15:0] b);
        return a[4:0] ^ b[4:0];
    endfunction
    function automatic logic [3:0] fake_cc(input logic [15:0] a, input logic [15:0] b);
        return a[3:0] ^ b[3:0];
    endfunction

    logic [15:0] dv_a = '0, dv_b = '0;
    logic        dv_busy = 1'b0, dv_done = 1'b0;
    int          dv_cnt = 0;
    bit          dv_slow = 1'b0;
    bit          spurious = 1'b0;
    int          cyc = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (divReset) begin
            dv_busy <= 1'b0;
            dv_done <= 1'b0;
        end else if (divStart) begin
            dv_a    <= divIn1;
            dv_b    <= divIn2;
            dv_busy <= 1'b1;
            dv_cnt  <= dv_slow ? 12 : int'($urandom_range(0, 4));
        end else if (dv_busy && !dv_done) begin
            if (dv_cnt == 0) dv_done <= 1'b1;
            else             dv_cnt  <= dv_cnt - 1;
        end
    end
    assign divDone  = dv_done | spurious;
    assign divOut   = fake_q(dv_a, dv_b);
    assign divFlags = fake_f(dv_a, dv_b);
    assign divCC    = fake_cc(dv_a, dv_b);

    typedef struct {
        logic [15:0]       r;
        logic [TAG_W-1:0]  t;
        logic [FLAG_W-1:0] f;
        logic [3:0]        cc;
        bit                byp;
    } exp_t;

    // Expected response for a request, straight from the operand rules.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
        exp_t e;
        bit a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        logic s;
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        a_zero = (a[14:0] == 15'h0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        b_zero = (b[14:0] == 15'h0);
        s      = a[15] ^ b[15];
        e.t = t; e.r = fake_q(a, b); e.f = fake_f(a, b); e.cc = fake_cc(a, b); e.byp = 1'b0;
`ifdef FPU_DIV_SPECIAL_BYPASS_EN
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            e.byp = 1'b1; e.r = 16'h7E00; e.f = 5'b10000;
        end else if (a_inf) begin
            e.byp = 1'b1; e.r = {s, 15'h7C00}; e.f = 5'b00000;
        end else if (b_zero) begin
            e.byp = 1'b1; e.r = {s, 15'h7C00}; e.f = 5'b01000;
        end else if (b_inf || a_zero) begin
            e.byp = 1'b1; e.r = {s, 15'h0000}; e.f = 5'b00000;
        end
        if (e.byp) e.cc = {(e.r[14:0] == 15'h0), 1'b0, e.r[15], 1'b0};
`else
        if (a_nan || a_inf || a_zero || b_nan || b_inf || b_zero) e.byp = 1'b0;
`endif
        return e;
    endfunction

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    exp_t exp_q[$];
    int start_cnt = 0, exp_starts = 0, resp_cnt = 0, dreset_cnt = 0;
    int push_cyc = -1, start_cyc = -1, rise_cyc = -1, dreset_cyc = -1;
    logic [15:0] last_r = '0;
    logic [TAG_W-1:0] last_t = '0;
    logic [FLAG_W-1:0] last_f = '0;

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        exp_t e;
        bit hold, prev_valid;
        logic [15:0] held_r;
        logic [TAG_W-1:0] held_t;
        hold = 1'b0; prev_valid = 1'b0; held_r = '0; held_t = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold = 1'b0; prev_valid = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(respValid), 32'(1));
                    chk("hold_result", 32'(respResult), 32'(held_r));
                    chk("hold_tag", 32'(respTag), 32'(held_t));
                end
                if (dv_busy) begin
                    chk("divIn1_stable", 32'(divIn1), 32'(dv_a));
                    chk("divIn2_stable", 32'(divIn2), 32'(dv_b));
                end
                if (reqValid && reqReady) begin
                    e = model(reqA, reqB, reqTag);
                    if (!e.byp) exp_starts++;
                    exp_q.push_back(e);
                    push_cyc = cyc;
                end
                if (divStart) begin start_cnt++; start_cyc = cyc; end
                if (divReset) begin dreset_cnt++; dreset_cyc = cyc; end
                if (respValid && !prev_valid) rise_cyc = cyc;
                if (respValid && respReady) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 32'(respValid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_result", 32'(respResult), 32'(e.r));
                        chk("resp_tag", 32'(respTag), 32'(e.t));
                        chk("resp_flags", 32'(respFlags), 32'(e.f));
                        chk("resp_cc", 32'(respCC), 32'(e.cc));
                    end
                    last_r = respResult; last_t = respTag; last_f = respFlags;
                    resp_cnt++;
                    $display("resp tag=%0d result=%h flags=%b cc=%b cycle=%0d",
                             respTag, respResult, respFlags, respCC, cyc);
                end
                hold = respValid && !respReady;
                held_r = respResult; held_t = respTag;
                prev_valid = respValid;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t, input bit rnd);
        int n;
        n = 0;
        reqValid = 1'b1; reqA = a; reqB = b; reqTag = t;
        while (!reqReady && n < 300) begin
            if (rnd) respReady = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("send_timeout", 32'(n < 300), 32'(1));
        if (rnd) respReady = 1'($urandom_range(0, 1));
        tick();
        reqValid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 500) begin tick(); n++; end
        chk("resp_timeout", 32'(n < 500), 32'(1));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!respValid && n < 500) begin tick(); n++; end
        chk("valid_timeout", 32'(n < 500), 32'(1));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7D01;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int s0, r0, d0, n;
        // Reset state
        tick(); tick();
        chk("rst_respValid", 32'(respValid), 32'(0));
        chk("rst_reqReady", 32'(reqReady), 32'(0));
        chk("rst_divReset", 32'(divReset), 32'(1));
        chk("rst_divStart", 32'(divStart), 32'(0));
        chk("rst_divIn1", 32'(divIn1), 32'(0));
        chk("rst_divIn2", 32'(divIn2), 32'(0));
        chk("rst_respResult", 32'(respResult), 32'(0));
        chk("rst_respTag", 32'(respTag), 32'(0));
        chk("rst_respFlags", 32'(respFlags), 32'(0));
        chk("rst_respCC", 32'(respCC), 32'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_reqReady", 32'(reqReady), 32'(1));
        chk("post_rst_divReset", 32'(divReset), 32'(0));

        // Single divide 6/2
        respReady = 1'b1;
        s0 = start_cnt; d0 = dreset_cnt; r0 = resp_cnt;
        send(16'h4600, 16'h4000, 4'd3, 1'b0);
        wait_resp(r0 + 1);
        repeat (3) tick();
        chk("t1_result", 32'(last_r), 32'h4200);
        chk("t1_tag", 32'(last_t), 32'd3);
        chk("t1_starts", 32'(start_cnt - s0), 32'd1);
        chk("t1_divreset_pulses", 32'(dreset_cnt - d0), 32'd1);
        chk("t1_launch_latency", 32'(start_cyc), 32'(push_cyc + 2));
        chk("t1_clear_after_capture", 32'(dreset_cyc), 32'(rise_cyc));

        // Back-to-back 1/1, tags 0..3
        s0 = start_cnt; r0 = resp_cnt;
        for (int i = 0; i < 4; i++) send(16'h3C00, 16'h3C00, TAG_W'(i), 1'b0);
        wait_resp(r0 + 4);
        chk("b2b_starts", 32'(start_cnt - s0), 32'd4);
        chk("b2b_last_tag", 32'(last_t), 32'd3);
        chk("b2b_last_result", 32'(last_r), 32'h3C00);

        // Response held 20 cycles; nothing new issues meanwhile
        respReady = 1'b0; r0 = resp_cnt;
        send(16'h4400, 16'h4000, 4'd5, 1'b0);
        wait_valid();
        s0 = start_cnt;
        send(16'h4200, 16'h3C00, 4'd6, 1'b0);
        repeat (20) tick();
        chk("held_no_issue", 32'(start_cnt), 32'(s0));
        chk("held_valid", 32'(respValid), 32'(1));
        respReady = 1'b1;
        wait_resp(r0 + 2);

        // Fill the FIFO behind a held response; fifth request stalls
        respReady = 1'b0; r0 = resp_cnt;
        send(16'h3C00, 16'h3C00, 4'd7, 1'b0);
        wait_valid();
        for (int i = 8; i < 12; i++) send(16'h3C00, 16'h3C00, TAG_W'(i), 1'b0);
        chk("full_reqReady", 32'(reqReady), 32'(0));
        s0 = start_cnt;
        reqValid = 1'b1; reqA = 16'h4000; reqB = 16'h3C00; reqTag = 4'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_stall", 32'(reqReady), 32'(0));
        end
        chk("full_no_issue", 32'(start_cnt), 32'(s0));
        respReady = 1'b1;
        send(16'h4000, 16'h3C00, 4'd12, 1'b0);
        chk("fifth_accept_cycle", 32'(push_cyc), 32'(start_cyc));
        wait_resp(r0 + 6);
        chk("fifth_result", 32'(last_r), 32'h4000);

        // Done asserted outside WAIT must be ignored
        s0 = start_cnt; r0 = resp_cnt;
        spurious = 1'b1;
        repeat (4) tick();
        spurious = 1'b0;
        tick();
        chk("spurious_valid", 32'(respValid), 32'(0));
        chk("spurious_starts", 32'(start_cnt), 32'(s0));
        chk("spurious_resps", 32'(resp_cnt), 32'(r0));

        // Randomized traffic
        for (int i = 0; i < 40; i++) send(pick(), pick(), TAG_W'($urandom), 1'b1);
        respReady = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
        chk("random_drain", 32'(exp_q.size()), 32'(0));

        // Reset while the divider is busy
        dv_slow = 1'b1;
        s0 = start_cnt;
        send(16'h3C00, 16'h3C00, 4'd1, 1'b0);
        n = 0;
        while (start_cnt == s0 && n < 50) begin tick(); n++; end
        chk("wait_start_timeout", 32'(n < 50), 32'(1));
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("midrst_respValid", 32'(respValid), 32'(0));
        chk("midrst_divReset", 32'(divReset), 32'(1));
        chk("midrst_reqReady", 32'(reqReady), 32'(0));
        tick(); tick();
        exp_q.delete();
        reset = 1'b0;
        dv_slow = 1'b0;
        s0 = start_cnt; r0 = resp_cnt;
        repeat (20) tick();
        chk("midrst_no_resp", 32'(resp_cnt), 32'(r0));
        chk("midrst_fifo_empty", 32'(start_cnt), 32'(s0));
        send(16'h4000, 16'h3C00, 4'd2, 1'b0);
        wait_resp(r0 + 1);
        chk("midrst_next_result", 32'(last_r), 32'h4000);
        chk("midrst_next_tag", 32'(last_t), 32'd2);

`ifdef FPU_DIV_SPECIAL_BYPASS_EN
        // Local special-case answers
        s0 = start_cnt; r0 = resp_cnt;
        send(16'h3C00, 16'h0000, 4'd4, 1'b0);
        wait_resp(r0 + 1);
        chk("byp_dz_result", 32'(last_r), 32'h7C00);
        chk("byp_dz_flags", 32'(last_f), 32'h08);
        chk("byp_latency", 32'(rise_cyc), 32'(push_cyc + 2));
        send(16'h0000, 16'h0000, 4'd5, 1'b0);
        wait_resp(r0 + 2);
        chk("byp_nv_result", 32'(last_r), 32'h7E00);
        chk("byp_nv_flags", 32'(last_f), 32'h10);
        chk("byp_no_start", 32'(start_cnt), 32'(s0));
`endif

        repeat (5) tick();
        chk("start_count", 32'(start_cnt), 32'(exp_starts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
